// File: rtl/ram_mutex_pkg.sv
// rtl/ram_mutex_pkg.sv - shared word encodings and state codes for the stack-RAM mutex
package ram_mutex_pkg;

  localparam logic [15:0] START_BASE = 16'hFC00;
  localparam logic [15:0] STOP_WORD  = 16'hFCFF;
  localparam logic [15:0] IDLE_WORD  = 16'h0000;
  localparam logic [3:0]  OP_TAG     = 4'b1100;

  localparam logic [1:0]  OP_RD   = 2'b00;
  localparam logic [1:0]  OP_WR   = 2'b01;
  localparam logic [1:0]  OP_DROP = 2'b10;
  localparam logic [1:0]  OP_NEW  = 2'b11;

  localparam logic [7:0]  TAG_N0 = 8'h01;
  localparam logic [7:0]  TAG_N1 = 8'h02;

  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_REQ     = 3'd1;
  localparam logic [2:0]  ST_OWN     = 3'd2;
  localparam logic [2:0]  ST_RD_WAIT = 3'd3;
  localparam logic [2:0]  ST_REL     = 3'd4;
  localparam logic [2:0]  ST_GAP     = 3'd5;

  function automatic logic [15:0] op_word(input logic [1:0] op, input logic [7:0] data);
    return {2'b00, op, OP_TAG, data};
  endfunction

endpackage

// File: rtl/ram_mutex_client_seq.sv
// rtl/ram_mutex_client_seq.sv - per-node sequencer from valid/ready commands to the mutex word protocol
module ram_mutex_client_seq
  import ram_mutex_pkg::*;
#(
  parameter int NODE_ID  = 0,
  parameter int PRIORITY = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_last,
  output logic [15:0] mtx_out,
  input  logic [15:0] mtx_in,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        err_tmo
);

  localparam logic [3:0]  PRIO       = (PRIORITY == 0) ? 4'd1 : 4'(PRIORITY);
  localparam logic [15:0] START_WORD = START_BASE | {12'h000, PRIO};
  localparam logic [7:0]  OWN_TAG    = (NODE_ID == 0) ? TAG_N0 : TAG_N1;
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] mtx_out_q, mtx_out_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;
  logic        err_tmo_q, err_tmo_d;
  logic [15:0] timer_q, timer_d;
  logic        rd_last_q, rd_last_d;
  logic        rd_ph_q, rd_ph_d;
  logic        granted;
  logic        issue;

  // Outputs are registered, so each cycle decides the word shown on the next one.
  // A command is only issued when cmd_valid is seen outside an accept cycle, which
  // keeps cmd_* stable between the decision and the handshake.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_tmo_d   = 1'b0;
    timer_d     = timer_q;
    rd_last_d   = rd_last_q;
    rd_ph_d     = 1'b0;
    issue       = 1'b0;
    granted     = (mtx_in[15:8] == OWN_TAG);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_REQ;
          timer_d = 16'h0000;
        end
      end
      ST_REQ: begin
        if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
        if (granted) begin
          state_d = ST_OWN;
          issue   = cmd_valid;
        end else if (timer_q == TMO_LAST) begin
          state_d   = ST_GAP;
          err_tmo_d = 1'b1;
        end
      end
      ST_OWN: begin
        if (cmd_ready_q) begin
          if (cmd_op == OP_RD) begin
            state_d   = ST_RD_WAIT;
            rd_last_d = cmd_last;
          end else if (cmd_last) begin
            state_d = ST_REL;
          end
        end else begin
          issue = cmd_valid;
        end
      end
      ST_RD_WAIT: begin
        // Phase 0 sees the mutex response; phase 1 shows rsp_valid before moving on.
        if (!rd_ph_q) begin
          if (granted) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mtx_in[7:0];
            rd_ph_d     = 1'b1;
          end else begin
            err_tmo_d = 1'b1;
            state_d   = ST_GAP;
          end
        end else if (rd_last_q) begin
          state_d = ST_REL;
        end else begin
          state_d = ST_OWN;
          issue   = cmd_valid;
        end
      end
      ST_REL:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_REQ, ST_RD_WAIT: mtx_out_d = START_WORD;
      ST_OWN:             mtx_out_d = issue ? op_word(cmd_op, cmd_data) : START_WORD;
      ST_REL:             mtx_out_d = STOP_WORD;
      default:            mtx_out_d = IDLE_WORD;
    endcase

    cmd_ready_d = issue;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mtx_out_q   <= IDLE_WORD;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
      timer_q     <= 16'h0000;
      rd_last_q   <= 1'b0;
      rd_ph_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtx_out_q   <= mtx_out_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      err_tmo_q   <= err_tmo_d;
      timer_q     <= timer_d;
      rd_last_q   <= rd_last_d;
      rd_ph_q     <= rd_ph_d;
    end
  end

  assign mtx_out   = mtx_out_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign err_tmo   = err_tmo_q;

endmodule
